if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipelined RISC-V core: owns the PC register, drives the instruction memory address, predicts next PC with a direct-mapped BTB plus 2-bit saturating counters, and produces the IF/ID pipeline register consumed by decode. Sits directly upstream of the ID stage (register file read, control unit, immediate generator). It accepts stall from the hazard unit, redirect and predictor updates from EX branch resolution, and halt from the ecall path.

## Interface
- BTB_IDX_W, 5, BTB index width; 2^BTB_IDX_W entries
- RESET_PC, 32'h0, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- stall_i  in  1  hold PC and IF/ID contents (load-use hazard)
- halt_i  in  1  stop fetching; PC frozen, IF/ID fed bubbles
- redirect_i  in  1  EX detected misprediction; flush IF/ID, load redirect_pc_i
- redirect_pc_i  in  32  correct next PC
- update_i  in  1  EX resolved a branch/jump; train predictor
- update_pc_i  in  32  PC of the resolved instruction
- update_taken_i  in  1  actual direction
- update_target_i  in  32  actual taken target
- imem_addr_o  out  32  to InstMemory addr (combinational read)
- imem_data_i  in  32  InstMemory dout
- if_id_inst_o  out  32  IF/ID instruction
- if_id_pc_o  out  32  IF/ID PC
- if_id_valid_o  out  1  IF/ID holds a real instruction
- if_id_pred_taken_o  out  1  prediction made for this instruction
- if_id_pred_target_o  out  32  predicted next PC (taken target or PC+4)

## Operation
- imem_addr_o = pc. Lookup: idx = pc[BTB_IDX_W+1:2], tag = pc[31:BTB_IDX_W+2]; hit = valid[idx] && tag match; pred_taken = hit && ctr[idx][1].
- pred_next = pred_taken ? target[idx] : pc+4 (32-bit wrap; 32'hFFFFFFFC+4 = 0).
- Next PC priority: redirect_i -> redirect_pc_i; else halt_i or stall_i -> pc; else pred_next.
- IF/ID priority: redirect_i -> bubble; else stall_i -> hold; else halt_i -> bubble; else load {imem_data_i, pc, 1, pred_taken, pred_next}.
- Bubble: inst = NOP (32'h00000013), valid = 0, pred_taken = 0, pc and pred_target = 0.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturating inc on taken, dec on not-taken.
- Update on update_i: if tag hit at update index -> increment/decrement counter, rewrite target if taken. On miss -> allocate: valid=1, tag, target = update_target_i, ctr = taken ? 10 : 01. Not-taken miss still allocates.
- update_i independent of stall/halt/redirect; always applied.

## Timing
- Reset: pc = RESET_PC; all BTB valid = 0, ctr = 01, tag/target = 0; IF/ID = bubble. Reset mid-operation discards everything in one edge; first fetch at RESET_PC the following cycle.
- Prediction combinational in same cycle as fetch; IF/ID visible 1 cycle after the PC is presented.
- Redirect: redirect_pc_i fetched the cycle after redirect_i; exactly one bubble enters IF/ID from this stage.
- Update and lookup on same index in same cycle: lookup sees pre-update contents; new contents visible next cycle.
- stall_i and redirect_i together: redirect wins. halt_i deasserted: fetch resumes at frozen pc.

## Structure
- Package if_pkg: NOP constant, counter encodings and SNT/WNT/WT/ST names, btb entry typedef {valid, tag, target, ctr}, counter next-state function.
- One sub-module: btb (storage array, combinational read port, single synchronous update port with saturating-counter logic). PC mux and IF/ID register stay in if_stage.

## Test plan
- Reset, imem returns 32'h00500093 at 0 -> cycle 1 if_id_inst_o = 32'h00500093, pc 0, valid 1; next imem_addr_o = 4, sequential thereafter.
- update_i at pc 0x10, taken, target 0x40; then fetch 0x10 -> pred_taken 1, pred_target 0x40, imem_addr_o = 0x40 next cycle.
- Four taken updates then three not-taken at 0x10 -> counter 11 then 00; prediction taken after 1st taken, not-taken after 2nd not-taken.
- stall_i held 3 cycles at pc 0x8 -> pc and IF/ID unchanged; stall_i plus redirect_i to 0x100 same cycle -> IF/ID bubble, next fetch 0x100.
- halt_i asserted at pc 0x20 -> IF/ID bubbles with valid 0, pc stays 0x20; deassert -> inst at 0x20 enters IF/ID.
- Update at 0x10 and fetch of 0x10 same cycle -> fetch sees old (miss, pc+4 = 0x14); following fetch of 0x10 hits.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP          : canonical bubble instruction (addi x0, x0, 0)
//   ctr_e        : 2-bit saturating branch-direction counter states
//   btb_entry_t  : one BTB line {valid, tag, target, ctr}
//   ctr_next     : saturating counter next-state
//   pc_tag       : tag portion of a PC for a given index width
package if_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Tag field is sized for the smallest useful index; narrower tags are
  // zero-extended so the entry type does not depend on the BTB depth.
  localparam int unsigned TAG_W_MAX = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    ctr_e                 ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_e'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

  function automatic logic [TAG_W_MAX-1:0] pc_tag(input logic [31:0] pc,
                                                  input int unsigned idx_w);
    return TAG_W_MAX'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/if_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   clk, reset          : clock, synchronous active-high reset
//   lookup_pc_i         : PC being fetched (combinational read)
//   taken_o, target_o   : predicted direction and taken target
//   update_i ...        : training port from EX branch resolution;
//                         a miss allocates the line, even when not taken
// A lookup and an update to the same line in one cycle: lookup returns
// the pre-update contents.
module btb
  import if_pkg::*;
#(
  parameter int unsigned IDX_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc_i,
  output logic        taken_o,
  output logic [31:0] target_o,
  input  logic        update_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  btb_entry_t mem_q [DEPTH];
  btb_entry_t mem_d [DEPTH];

  logic [IDX_W-1:0]     lk_idx;
  btb_entry_t           lk_entry;
  logic                 lk_hit;
  logic [IDX_W-1:0]     up_idx;
  logic [TAG_W_MAX-1:0] up_tag;
  btb_entry_t           up_entry;

  always_comb begin
    lk_idx   = lookup_pc_i[IDX_W+1:2];
    lk_entry = mem_q[lk_idx];
    lk_hit   = lk_entry.valid && (lk_entry.tag == pc_tag(lookup_pc_i, IDX_W));
    taken_o  = lk_hit && ((lk_entry.ctr == WT) || (lk_entry.ctr == ST));
    target_o = lk_entry.target;
  end

  always_comb begin
    mem_d    = mem_q;
    up_idx   = update_pc_i[IDX_W+1:2];
    up_tag   = pc_tag(update_pc_i, IDX_W);
    up_entry = mem_q[up_idx];
    if (update_i) begin
      if (up_entry.valid && (up_entry.tag == up_tag)) begin
        up_entry.ctr = ctr_next(up_entry.ctr, update_taken_i);
        if (update_taken_i) up_entry.target = update_target_i;
      end else begin
        up_entry.valid  = 1'b1;
        up_entry.tag    = up_tag;
        up_entry.target = update_target_i;
        up_entry.ctr    = update_taken_i ? WT : WNT;
      end
      mem_d[up_idx] = up_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction memory address,
// BTB-based next-PC prediction and the IF/ID pipeline register.
//   clk, reset            : clock, synchronous active-high reset
//   stall_i               : hold PC and IF/ID
//   halt_i                : freeze PC, feed bubbles into IF/ID
//   redirect_i/_pc_i      : EX misprediction; flush IF/ID, load new PC
//   update_*              : predictor training from EX
//   imem_addr_o/imem_data_i : combinational instruction memory port
//   if_id_*_o             : IF/ID register contents for decode
module if_stage
  import if_pkg::*;
#(
  parameter int unsigned BTB_IDX_W = 5,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        update_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] if_id_inst_o,
  output logic [31:0] if_id_pc_o,
  output logic        if_id_valid_o,
  output logic        if_id_pred_taken_o,
  output logic [31:0] if_id_pred_target_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        valid_q, valid_d;
  logic        pt_q, pt_d;
  logic [31:0] ptgt_q, ptgt_d;

  logic        pred_taken;
  logic [31:0] btb_target;
  logic [31:0] pred_next;

  btb #(
    .IDX_W(BTB_IDX_W)
  ) u_btb (
    .clk            (clk),
    .reset          (reset),
    .lookup_pc_i    (pc_q),
    .taken_o        (pred_taken),
    .target_o       (btb_target),
    .update_i       (update_i),
    .update_pc_i    (update_pc_i),
    .update_taken_i (update_taken_i),
    .update_target_i(update_target_i)
  );

  assign imem_addr_o = pc_q;

  always_comb begin
    pred_next = pred_taken ? btb_target : pc_q + 32'd4;

    if (redirect_i)             pc_d = redirect_pc_i;
    else if (halt_i || stall_i) pc_d = pc_q;
    else                        pc_d = pred_next;

    inst_d  = inst_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    pt_d    = pt_q;
    ptgt_d  = ptgt_q;
    // Redirect outranks stall so a flushed wrong-path instruction never
    // lingers in IF/ID; halt only bubbles when decode is not stalled.
    if (redirect_i || (!stall_i && halt_i)) begin
      inst_d  = NOP;
      id_pc_d = '0;
      valid_d = 1'b0;
      pt_d    = 1'b0;
      ptgt_d  = '0;
    end else if (!stall_i) begin
      inst_d  = imem_data_i;
      id_pc_d = pc_q;
      valid_d = 1'b1;
      pt_d    = pred_taken;
      ptgt_d  = pred_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      id_pc_q <= '0;
      valid_q <= 1'b0;
      pt_q    <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
      pt_q    <= pt_d;
      ptgt_q  <= ptgt_d;
    end
  end

  assign if_id_inst_o        = inst_q;
  assign if_id_pc_o          = id_pc_q;
  assign if_id_valid_o       = valid_q;
  assign if_id_pred_taken_o  = pt_q;
  assign if_id_pred_target_o = ptgt_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP_I = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, stall_i, halt_i, redirect_i, update_i, update_taken_i;
  logic [31:0] redirect_pc_i, update_pc_i, update_target_i;
  logic [31:0] imem_addr_o, imem_data_i;
  logic [31:0] if_id_inst_o, if_id_pc_o, if_id_pred_target_o;
  logic        if_id_valid_o, if_id_pred_taken_o;

  always #5 clk = ~clk;

  if_stage #(.BTB_IDX_W(5), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .halt_i(halt_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .update_i(update_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .update_target_i(update_target_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .if_id_inst_o(if_id_inst_o), .if_id_pc_o(if_id_pc_o),
    .if_id_valid_o(if_id_valid_o), .if_id_pred_taken_o(if_id_pred_taken_o),
    .if_id_pred_target_o(if_id_pred_target_o)
  );

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return a * 32'h9E3779B1 + 32'd1;
  endfunction

  always_comb imem_data_i = imem_fn(imem_addr_o);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predictor as a table of per-line records, counter as an
  // integer strength 0..3 clamped at the ends.
  bit          b_valid [32];
  int unsigned b_tag   [32];
  logic [31:0] b_tgt   [32];
  int          b_ctr   [32];
  logic [31:0] m_pc, m_inst, m_idpc, m_ptgt;
  bit          m_valid, m_pt;

  task automatic m_bubble();
    m_inst = NOP_I; m_idpc = 0; m_valid = 0; m_pt = 0; m_ptgt = 0;
  endtask

  task automatic m_step(input bit rst, input bit st, input bit hl, input bit rd,
                        input logic [31:0] rpc, input bit up, input logic [31:0] upc,
                        input bit utk, input logic [31:0] utgt);
    int unsigned li, ui;
    bit pt;
    logic [31:0] pn;
    if (rst) begin
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) begin
        b_valid[i] = 0; b_tag[i] = 0; b_tgt[i] = 0; b_ctr[i] = 1;
      end
      m_bubble();
      return;
    end
    li = (m_pc / 4) % 32;
    pt = b_valid[li] && (b_tag[li] == m_pc / 128) && (b_ctr[li] >= 2);
    pn = pt ? b_tgt[li] : m_pc + 32'd4;
    if (rd) m_bubble();
    else if (st) ;
    else if (hl) m_bubble();
    else begin
      m_inst = imem_fn(m_pc); m_idpc = m_pc; m_valid = 1; m_pt = pt; m_ptgt = pn;
    end
    if (rd) m_pc = rpc;
    else if (!(st || hl)) m_pc = pn;
    if (up) begin
      ui = (upc / 4) % 32;
      if (b_valid[ui] && b_tag[ui] == upc / 128) begin
        b_ctr[ui] = utk ? ((b_ctr[ui] == 3) ? 3 : b_ctr[ui] + 1)
                        : ((b_ctr[ui] == 0) ? 0 : b_ctr[ui] - 1);
        if (utk) b_tgt[ui] = utgt;
      end else begin
        b_valid[ui] = 1; b_tag[ui] = upc / 128; b_tgt[ui] = utgt;
        b_ctr[ui] = utk ? 2 : 1;
      end
    end
  endtask

  // Called at a negedge; inputs held through the next posedge, outputs
  // compared at the following negedge.
  task automatic do_cycle(input bit rst, input bit st, input bit hl, input bit rd,
                          input logic [31:0] rpc, input bit up, input logic [31:0] upc,
                          input bit utk, input logic [31:0] utgt);
    reset = rst; stall_i = st; halt_i = hl; redirect_i = rd; redirect_pc_i = rpc;
    update_i = up; update_pc_i = upc; update_taken_i = utk; update_target_i = utgt;
    #1;
    if (!$isunknown(m_pc)) chk("imem_addr", imem_addr_o, m_pc);
    @(posedge clk);
    m_step(rst, st, hl, rd, rpc, up, upc, utk, utgt);
    @(negedge clk);
    chk("id_inst", if_id_inst_o, m_inst);
    chk("id_pc", if_id_pc_o, m_idpc);
    chk("id_valid", {31'b0, if_id_valid_o}, {31'b0, m_valid});
    chk("id_pred_taken", {31'b0, if_id_pred_taken_o}, {31'b0, m_pt});
    chk("id_pred_target", if_id_pred_target_o, m_ptgt);
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input logic [31:0] pc);
    do_cycle(0, 0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit st, hl, rd; logic [31:0] rpc;
    bit up, utk; logic [31:0] upc, utgt;
    logic [31:0] e_addr, e_idpc; bit e_valid, e_pt;
  } vec_t;

  function automatic vec_t mk(bit st, bit hl, bit rd, logic [31:0] rpc, bit up, bit utk,
                              logic [31:0] upc, logic [31:0] utgt, logic [31:0] e_addr,
                              logic [31:0] e_idpc, bit e_valid, bit e_pt);
    vec_t v;
    v.st = st; v.hl = hl; v.rd = rd; v.rpc = rpc; v.up = up; v.utk = utk;
    v.upc = upc; v.utgt = utgt; v.e_addr = e_addr; v.e_idpc = e_idpc;
    v.e_valid = e_valid; v.e_pt = e_pt;
    return v;
  endfunction

  vec_t tbl[16];
  bit   pat_tk [7] = '{1, 1, 1, 1, 0, 0, 0};
  bit   pat_pt [7] = '{1, 1, 1, 1, 1, 0, 0};

  initial begin
    m_pc = 'x;
    //            st hl rd rpc       up tk upc    utgt   addr   idpc   v  pt
    tbl[0]  = mk(0, 0, 0, 0,        0, 0, 0,     0,     32'h4,  32'h0,  1, 0);
    tbl[1]  = mk(0, 0, 0, 0,        1, 1, 32'h10, 32'h40, 32'h8, 32'h4,  1, 0);
    tbl[2]  = mk(1, 0, 0, 0,        0, 0, 0,     0,     32'h8,  32'h4,  1, 0);
    tbl[3]  = mk(1, 0, 0, 0,        0, 0, 0,     0,     32'h8,  32'h4,  1, 0);
    tbl[4]  = mk(1, 0, 0, 0,        0, 0, 0,     0,     32'h8,  32'h4,  1, 0);
    tbl[5]  = mk(0, 0, 0, 0,        0, 0, 0,     0,     32'hC,  32'h8,  1, 0);
    tbl[6]  = mk(0, 0, 0, 0,        0, 0, 0,     0,     32'h10, 32'hC,  1, 0);
    tbl[7]  = mk(0, 0, 0, 0,        0, 0, 0,     0,     32'h40, 32'h10, 1, 1);
    tbl[8]  = mk(1, 0, 1, 32'h100,  0, 0, 0,     0,     32'h100, 32'h0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,        0, 0, 0,     0,     32'h104, 32'h100, 1, 0);
    tbl[10] = mk(0, 0, 1, 32'h20,   0, 0, 0,     0,     32'h20, 32'h0,  0, 0);
    tbl[11] = mk(0, 1, 0, 0,        0, 0, 0,     0,     32'h20, 32'h0,  0, 0);
    tbl[12] = mk(0, 1, 0, 0,        0, 0, 0,     0,     32'h20, 32'h0,  0, 0);
    tbl[13] = mk(0, 0, 0, 0,        0, 0, 0,     0,     32'h24, 32'h20, 1, 0);
    tbl[14] = mk(0, 0, 1, 32'h10,   1, 0, 32'h10, 32'h0, 32'h10, 32'h0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,        0, 0, 0,     0,     32'h14, 32'h10, 1, 0);

    reset = 1; stall_i = 0; halt_i = 0; redirect_i = 0; redirect_pc_i = 0;
    update_i = 0; update_pc_i = 0; update_taken_i = 0; update_target_i = 0;
    @(negedge clk);

    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_inst", if_id_inst_o, NOP_I);
    chk("rst_valid", {31'b0, if_id_valid_o}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      do_cycle(0, tbl[i].st, tbl[i].hl, tbl[i].rd, tbl[i].rpc,
               tbl[i].up, tbl[i].upc, tbl[i].utk, tbl[i].utgt);
      if (i == 0) chk("first_inst", if_id_inst_o, 32'h00500093);
      chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_idpc", i), if_id_pc_o, tbl[i].e_idpc);
      chk($sformatf("tbl%0d_valid", i), {31'b0, if_id_valid_o}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_pt", i), {31'b0, if_id_pred_taken_o}, {31'b0, tbl[i].e_pt});
    end

    // Counter training: four taken then three not-taken at 0x30.
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      do_cycle(0, 0, 0, 1, 32'h30, 1, 32'h30, pat_tk[k], 32'h80);
      idle();
      chk($sformatf("train%0d_pt", k), {31'b0, if_id_pred_taken_o}, {31'b0, pat_pt[k]});
    end

    // Same-cycle update and lookup on one line.
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    redir(32'h10);
    do_cycle(0, 0, 0, 0, 0, 1, 32'h10, 1, 32'h40);
    chk("same_cyc_pt", {31'b0, if_id_pred_taken_o}, 32'h0);
    chk("same_cyc_tgt", if_id_pred_target_o, 32'h14);
    chk("same_cyc_addr", imem_addr_o, 32'h14);
    redir(32'h10);
    idle();
    chk("after_upd_pt", {31'b0, if_id_pred_taken_o}, 32'h1);
    chk("after_upd_tgt", if_id_pred_target_o, 32'h40);
    chk("after_upd_addr", imem_addr_o, 32'h40);

    // PC wrap at the top of the address space.
    redir(32'hFFFFFFFC);
    idle();
    chk("wrap_addr", imem_addr_o, 32'h0);

    // Randomized traffic against the model, including mid-run resets.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc, upc, utgt;
      rpc  = {23'($urandom_range(0, 3)), 7'($urandom_range(0, 31)), 2'b00};
      upc  = {23'($urandom_range(0, 3)), 7'($urandom_range(0, 31)), 2'b00};
      utgt = {23'($urandom_range(0, 3)), 7'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 29) == 0) rpc = 32'hFFFFFFFC;
      do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, rpc,
               $urandom_range(0, 4) < 2, upc, 1'($urandom_range(0, 1)), utgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
